// File: rtl/dff_ram_pkg.sv
// Shared types and elaboration helpers for the banked flop RAM.
// Holds the FSM state type, the parameter legality check and the lane-mask expander.
package dff_ram_pkg;

    localparam int unsigned MAX_WIDTH   = 1024;
    localparam int unsigned MAX_NL      = 128;
    localparam int unsigned MAX_WIDTH_W = 10;
    localparam int unsigned MAX_NL_W    = 7;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_IDLE
    } state_e;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned lane_w,
                                        input int unsigned depth, input int unsigned bank_depth);
        if (lane_w == 0 || width == 0) return 1'b0;
        if ((width % lane_w) != 0 || width > MAX_WIDTH || (width / lane_w) > MAX_NL) return 1'b0;
        if (!is_pow2(depth) || !is_pow2(bank_depth) || bank_depth < 2) return 1'b0;
        return ((depth % bank_depth) == 0) && (depth >= bank_depth);
    endfunction

    // Bit i of the result copies mask[i / lane_w]; bits past nl*lane_w stay zero.
    function automatic logic [MAX_WIDTH-1:0] expand_mask(input logic [MAX_NL-1:0] mask,
                                                         input int unsigned nl,
                                                         input int unsigned lane_w);
        logic [MAX_WIDTH-1:0] wbe;
        wbe = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (lane_w != 0 && i < nl * lane_w) begin
                wbe[MAX_WIDTH_W'(i)] = mask[MAX_NL_W'(i / lane_w)];
            end
        end
        return wbe;
    endfunction

endpackage

// File: rtl/dff_ram_bank.sv
// One bank of the flop RAM: combinational read, bit-masked synchronous write, no reset.
module dff_ram_bank #(
    parameter int unsigned WIDTH      = 72,
    parameter int unsigned BANK_DEPTH = 4,
    parameter int unsigned LANE_W     = 9
) (
    input  logic                          clk,
    input  logic                          en_n,
    input  logic                          wr_n,
    input  logic [$clog2(BANK_DEPTH)-1:0] add,
    input  logic [WIDTH-1:0]              wbe,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata
);

    if ((WIDTH % LANE_W) != 0) begin : g_lane_err
        $error("dff_ram_bank: WIDTH must be a multiple of LANE_W");
    end

    logic [WIDTH-1:0] mem_q [BANK_DEPTH];

    always_ff @(posedge clk) begin
        if (!en_n && !wr_n) begin
            mem_q[add] <= (mem_q[add] & ~wbe) | (wdata & wbe);
        end
    end

    assign rdata = mem_q[add];

endmodule

// File: rtl/dff_ram_banked.sv
// Banked single-port flop RAM with lane write mask, registered read and a zeroing sweep
// that runs after reset and on a clear request.
module dff_ram_banked
    import dff_ram_pkg::*;
#(
    parameter int unsigned  WIDTH      = 72,
    parameter int unsigned  LANE_W     = 9,
    parameter int unsigned  DEPTH      = 8,
    parameter int unsigned  BANK_DEPTH = 4,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned NL         = WIDTH / LANE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_n,
    input  logic             wr_n,
    input  logic [AW-1:0]    add,
    input  logic [NL-1:0]    wmask,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             ready
);

    localparam int unsigned BW = $clog2(BANK_DEPTH);
    localparam int unsigned NB = DEPTH / BANK_DEPTH;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

    if (!params_legal(WIDTH, LANE_W, DEPTH, BANK_DEPTH)) begin : g_param_err
        $error("dff_ram_banked: illegal WIDTH/LANE_W/DEPTH/BANK_DEPTH combination");
    end

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [AW-1:0]    mem_addr;
    logic [IW-1:0]    mem_bank;
    logic [BW-1:0]    mem_word;
    logic             mem_acc;
    logic             mem_we;
    logic [WIDTH-1:0] mem_wbe;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] wbe_user;
    logic [NB-1:0]    bank_en_n;
    logic [WIDTH-1:0] bank_rdata [NB];

    // The sweep owns the array while in INIT, so the address comes from the counter there.
    assign mem_addr = (state_q == ST_INIT) ? cnt_q : add;
    assign mem_word = mem_addr[BW-1:0];

    if (NB > 1) begin : g_multi_bank
        assign mem_bank = mem_addr[AW-1:BW];
    end else begin : g_single_bank
        assign mem_bank = '0;
    end

    assign wbe_user = WIDTH'(expand_mask(MAX_NL'(wmask), NL, LANE_W));

    always_comb begin
        mem_acc   = 1'b0;
        mem_we    = 1'b0;
        mem_wbe   = wbe_user;
        mem_wdata = wdata;
        if (state_q == ST_INIT) begin
            mem_acc   = 1'b1;
            mem_we    = 1'b1;
            mem_wbe   = '1;
            mem_wdata = '0;
        end else if (!clr && !en_n) begin
            mem_acc = 1'b1;
            mem_we  = !wr_n;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        assign bank_en_n[b] = !(mem_acc && (mem_bank == IW'(b)));

        dff_ram_bank #(
            .WIDTH      (WIDTH),
            .BANK_DEPTH (BANK_DEPTH),
            .LANE_W     (LANE_W)
        ) u_bank (
            .clk   (clk),
            .en_n  (bank_en_n[b]),
            .wr_n  (!mem_we),
            .add   (mem_word),
            .wbe   (mem_wbe),
            .wdata (mem_wdata),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else if (!en_n && wr_n) begin
                    rvalid_d = 1'b1;
                    rdata_d  = bank_rdata[mem_bank];
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_dff_ram_banked.sv
// Self-checking bench for dff_ram_banked at default parameters (72 bits x 8 words, 2 banks).
module tb_dff_ram_banked;

    localparam int W  = 72;
    localparam int D  = 8;
    localparam int LW = 9;
    localparam int NL = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_n;
    logic          wr_n;
    logic [2:0]    add;
    logic [NL-1:0] wmask;
    logic [W-1:0]  wdata;
    logic          clr;
    logic [W-1:0]  rdata;
    logic          rvalid;
    logic          ready;

    dff_ram_banked dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_n   (en_n),
        .wr_n   (wr_n),
        .add    (add),
        .wmask  (wmask),
        .wdata  (wdata),
        .clr    (clr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: memory contents, last read data, remaining sweep edges.
    logic [W-1:0] m_mem [D];
    logic [W-1:0] m_rdata;
    logic         m_rvalid;
    logic         m_ready;
    int           m_init_left;

    typedef struct {
        bit            en;
        bit            wr;
        logic [2:0]    add;
        logic [NL-1:0] wmask;
        logic [W-1:0]  wdata;
        bit            exp_rvalid;
        logic [W-1:0]  exp_rdata;
    } vec_t;

    vec_t vecs [12];

    localparam logic [W-1:0] D1 = 72'hA5_0123_4567_89AB_CDEF;
    localparam logic [W-1:0] D2 = 72'hA5_0123_4567_89AB_CDFF;
    localparam logic [W-1:0] DX = 72'h12_3456_789A_BCDE_F012;
    localparam logic [W-1:0] DY = 72'hFE_DCBA_9876_5432_10FE;
    localparam logic [W-1:0] DZ = 72'h3C_5A5A_0F0F_F0F0_1234;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en_n  = 1'b1;
        wr_n  = 1'b1;
        add   = '0;
        wmask = '0;
        wdata = '0;
        clr   = 1'b0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
    endtask

    // Applies the currently driven inputs to the model for one edge.
    task automatic model_edge();
        m_rvalid = 1'b0;
        if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) m_ready = 1'b1;
        end else if (clr) begin
            m_init_left = D;
            m_ready     = 1'b0;
            model_zero();
        end else if (!en_n) begin
            if (!wr_n) begin
                for (int l = 0; l < NL; l++)
                    if (wmask[l]) m_mem[add][l*LW +: LW] = wdata[l*LW +: LW];
            end else begin
                m_rdata  = m_mem[add];
                m_rvalid = 1'b1;
            end
        end
    endtask

    task automatic wait_ready_after_sweep(input string name);
        for (int i = 1; i <= D; i++) begin
            tick();
            chk(name, W'(ready), W'(i == D));
        end
    endtask

    function automatic vec_t mkv(input bit en, input bit wr, input logic [2:0] a,
                                 input logic [NL-1:0] m, input logic [W-1:0] d,
                                 input bit erv, input logic [W-1:0] erd);
        vec_t v;
        v.en = en; v.wr = wr; v.add = a; v.wmask = m; v.wdata = d;
        v.exp_rvalid = erv; v.exp_rdata = erd;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(1, 1, 3'd5, 8'hFF, D1,   0, '0);
        vecs[1]  = mkv(1, 0, 3'd5, 8'h00, '0,   1, D1);
        vecs[2]  = mkv(1, 1, 3'd5, 8'h01, ONES, 0, D1);
        vecs[3]  = mkv(1, 0, 3'd5, 8'h00, '0,   1, D2);
        vecs[4]  = mkv(1, 1, 3'd3, 8'hFF, DX,   0, D2);
        vecs[5]  = mkv(1, 1, 3'd4, 8'hFF, DY,   0, D2);
        vecs[6]  = mkv(1, 0, 3'd3, 8'h00, '0,   1, DX);
        vecs[7]  = mkv(1, 0, 3'd4, 8'h00, '0,   1, DY);
        vecs[8]  = mkv(1, 0, 3'd3, 8'h00, '0,   1, DX);
        vecs[9]  = mkv(0, 0, 3'd3, 8'h00, '0,   0, DX);
        vecs[10] = mkv(1, 1, 3'd5, 8'h00, ONES, 0, DX);
        vecs[11] = mkv(1, 0, 3'd5, 8'h00, '0,   1, D2);

        // Reset state.
        rst_n = 1'b0;
        idle_inputs();
        tick();
        chk("reset_rdata", rdata, '0);
        chk("reset_rvalid", W'(rvalid), '0);
        chk("reset_ready", W'(ready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready_after_sweep("post_reset_ready");

        // Every word reads zero after the sweep.
        for (int a = 0; a < D; a++) begin
            en_n = 1'b0; wr_n = 1'b1; add = 3'(a);
            tick();
            chk("init_read_rvalid", W'(rvalid), W'(1));
            chk("init_read_data", rdata, '0);
        end
        idle_inputs();
        tick();
        chk("idle_rvalid", W'(rvalid), '0);
        chk("idle_rdata_hold", rdata, '0);

        // Directed vectors: full write, lane mask, bank isolation, no-op mask.
        for (int i = 0; i < 12; i++) begin
            en_n  = !vecs[i].en;
            wr_n  = !vecs[i].wr;
            add   = vecs[i].add;
            wmask = vecs[i].wmask;
            wdata = vecs[i].wdata;
            tick();
            chk($sformatf("vec%0d_rvalid", i), W'(rvalid), W'(vecs[i].exp_rvalid));
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Clear with a simultaneous write; requests and clr during the sweep are dropped.
        en_n = 1'b0; wr_n = 1'b0; add = 3'd2; wmask = 8'hFF; wdata = 72'h1; clr = 1'b1;
        tick();
        chk("clr_ready_drop", W'(ready), '0);
        chk("clr_rvalid", W'(rvalid), '0);
        for (int i = 1; i <= D; i++) begin
            en_n = (i == 3) ? 1'b0 : 1'b1;
            wr_n = 1'b1; add = 3'd5;
            clr  = (i == 5);
            tick();
            chk("clr_sweep_ready", W'(ready), W'(i == D));
            if (i == 3) chk("init_req_dropped", W'(rvalid), '0);
        end
        idle_inputs();
        en_n = 1'b0; wr_n = 1'b1; add = 3'd2;
        tick();
        chk("clr_write_lost_rvalid", W'(rvalid), W'(1));
        chk("clr_write_lost_data", rdata, '0);
        add = 3'd5;
        tick();
        chk("clr_zeroed_word5", rdata, '0);

        // Randomised traffic against the reference model.
        model_zero();
        m_rdata = '0; m_rvalid = 1'b0; m_ready = 1'b1; m_init_left = 0;
        for (int c = 0; c < 300; c++) begin
            en_n  = ($urandom_range(0, 3) == 0);
            wr_n  = $urandom_range(0, 1) != 0;
            add   = 3'($urandom_range(0, D - 1));
            wmask = 8'($urandom);
            wdata = W'({$urandom, $urandom, $urandom});
            clr   = ($urandom_range(0, 63) == 0);
            model_edge();
            tick();
            chk("rand_rvalid", W'(rvalid), W'(m_rvalid));
            chk("rand_rdata", rdata, m_rdata);
            chk("rand_ready", W'(ready), W'(m_ready));
        end
        idle_inputs();
        while (m_init_left > 0) begin
            model_edge();
            tick();
        end
        chk("rand_settle_ready", W'(ready), W'(1));

        // Reset in the middle of a sweep, counter at 3.
        en_n = 1'b0; wr_n = 1'b0; add = 3'd7; wmask = 8'hFF; wdata = DZ;
        tick();
        wr_n = 1'b1;
        tick();
        chk("pre_clr_read", rdata, DZ);
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("mid_init_ready_low", W'(ready), '0);
        tick(); tick(); tick();
        chk("mid_init_rdata_hold", rdata, DZ);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_init_rst_rdata", rdata, '0);
        chk("mid_init_rst_rvalid", W'(rvalid), '0);
        chk("mid_init_rst_ready", W'(ready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready_after_sweep("mid_init_restart_ready");
        en_n = 1'b0; wr_n = 1'b1; add = 3'd7;
        tick();
        chk("mid_init_word7_zero", rdata, '0);

        // Reset while a read strobe is pending.
        en_n = 1'b0; wr_n = 1'b0; add = 3'd6; wdata = DZ; wmask = 8'hFF;
        tick();
        wr_n = 1'b1;
        tick();
        chk("mid_read_rvalid", W'(rvalid), W'(1));
        chk("mid_read_rdata", rdata, DZ);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_read_rst_rvalid", W'(rvalid), '0);
        chk("mid_read_rst_rdata", rdata, '0);
        chk("mid_read_rst_ready", W'(ready), '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready_after_sweep("mid_read_restart_ready");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
